// File: rtl/bubble_seq_pkg.sv
// ============================================================================
// Module   : bubble_seq_pkg
// Brief    : Shared state encoding, default 50 MHz timing and helpers for the
//            bubble host sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bubble_seq_pkg;

    localparam int unsigned c_cmd_cnt_w        = 8;

    localparam int unsigned c_pwr_dly_cyc      = 150000;
    localparam int unsigned c_boot_lead_cyc    = 25000;
    localparam int unsigned c_boot_shift_cyc   = 2193873;
    localparam int unsigned c_boot_loop_dly    = 212;
    localparam int unsigned c_lead_cyc         = 37500;
    localparam int unsigned c_rep_dly_cyc      = 500;
    localparam int unsigned c_rep_w_cyc        = 341;
    localparam int unsigned c_hold_cyc         = 336992;
    localparam int unsigned c_sample_div       = 4;

    typedef enum logic [3:0] {
        S_PWR        = 4'd0,
        S_WAIT_TEMP  = 4'd1,
        S_BOOT_LEAD  = 4'd2,
        S_BOOT_SHIFT = 4'd3,
        S_BOOT_LOOP  = 4'd4,
        S_READY      = 4'd5,
        S_LEAD       = 4'd6,
        S_SEEK       = 4'd7,
        S_REP        = 4'd8,
        S_HOLD       = 4'd9
    } seq_state_e;

    // Timer reload value giving a state length of max(n,1) cycles.
    function automatic int unsigned span(input int unsigned n);
        return (n == 32'd0) ? 32'd0 : n - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bubble_seq_timer.sv
// ============================================================================
// Module   : bubble_seq_timer
// Brief    : Loadable down-counter shared by every timed sequencer state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bubble_seq_timer #(
    parameter int               CNT_W   = 22,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             master_clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expire_o
);

    logic [CNT_W-1:0] value_q;

    always_ff @(posedge master_clock_i) begin
        if (reset_i) begin
            value_q <= RST_VAL;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (value_q != '0) begin
            value_q <= value_q - CNT_W'(1);
        end
    end

    assign value_o  = value_q;
    assign expire_o = (value_q == '0);

endmodule

`default_nettype wire

// File: rtl/bubble_host_sequencer.sv
// ============================================================================
// Module   : bubble_host_sequencer
// Brief    : Power/boot handshake and N-page shift/replicator burst sequencer.
//            Optional per-shift capture enabled by BUBBLE_SEQ_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bubble_host_sequencer
    import bubble_seq_pkg::*;
#(
    parameter int          CH             = 2,
    parameter int          CNT_W          = 22,
    parameter int unsigned PWR_DLY_CYC    = c_pwr_dly_cyc,
    parameter int unsigned BOOT_LEAD_CYC  = c_boot_lead_cyc,
    parameter int unsigned BOOT_SHIFT_CYC = c_boot_shift_cyc,
    parameter int unsigned BOOT_LOOP_DLY  = c_boot_loop_dly,
    parameter int unsigned LEAD_CYC       = c_lead_cyc,
    parameter int unsigned REP_DLY_CYC    = c_rep_dly_cyc,
    parameter int unsigned REP_W_CYC      = c_rep_w_cyc,
    parameter int unsigned HOLD_CYC       = c_hold_cyc,
    parameter int unsigned SAMPLE_DIV     = c_sample_div
) (
    input  logic                   master_clock_i,
    input  logic                   reset_i,
    input  logic                   temperature_low_i,
    input  logic [CH-1:0]          bubble_out_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [CNT_W-1:0]       cmd_seek_i,
    input  logic [c_cmd_cnt_w-1:0] cmd_count_i,
    output logic                   power_good_o,
    output logic                   bubble_shift_enable_o,
    output logic                   replicator_enable_o,
    output logic                   bootloop_enable_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CH-1:0]          data_out_o,
    output logic                   data_valid_o
);

    seq_state_e               state_q, state_d;
    logic                     pg_q, shift_q, rep_q, boot_q, busy_q, done_q, ready_q;
    logic                     temp_q, temp_prev_q, first_q;
    logic [c_cmd_cnt_w-1:0]   pages_q;
    logic [CNT_W-1:0]         seek_q;

    logic                     w_load, w_expire, w_accept, w_temp_rise;
    logic [CNT_W-1:0]         w_load_val, w_seek_span, w_timer_value;
    logic                     w_unused_timer;

    bubble_seq_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(span(PWR_DLY_CYC)))
    ) u_timer (
        .master_clock_i (master_clock_i),
        .reset_i        (reset_i),
        .load_i         (w_load),
        .load_val_i     (w_load_val),
        .value_o        (w_timer_value),
        .expire_o       (w_expire)
    );

    assign w_unused_timer = ^w_timer_value;
    assign w_accept       = cmd_valid_i & ready_q;
    assign w_temp_rise    = temp_q & ~temp_prev_q;
    assign w_seek_span    = (seek_q == '0) ? '0 : seek_q - CNT_W'(1);

    // Next state and timer reload; the reload always accompanies state entry.
    always_comb begin
        state_d    = state_q;
        w_load     = 1'b0;
        w_load_val = '0;
        case (state_q)
            S_PWR:        if (w_expire) state_d = S_WAIT_TEMP;
            S_WAIT_TEMP:  if (w_temp_rise) begin
                              state_d = S_BOOT_LEAD;  w_load = 1'b1;
                              w_load_val = CNT_W'(span(BOOT_LEAD_CYC));
                          end
            S_BOOT_LEAD:  if (w_expire) begin
                              state_d = S_BOOT_SHIFT; w_load = 1'b1;
                              w_load_val = CNT_W'(span(BOOT_SHIFT_CYC));
                          end
            S_BOOT_SHIFT: if (w_expire) begin
                              state_d = S_BOOT_LOOP;  w_load = 1'b1;
                              w_load_val = CNT_W'(span(BOOT_LOOP_DLY));
                          end
            S_BOOT_LOOP:  if (w_expire) state_d = S_READY;
            S_READY:      if (w_accept && cmd_count_i != '0) begin
                              state_d = S_LEAD;       w_load = 1'b1;
                              w_load_val = CNT_W'(span(LEAD_CYC));
                          end
            S_LEAD:       if (w_expire) begin
                              state_d = S_SEEK;       w_load = 1'b1;
                              w_load_val = first_q ? w_seek_span : CNT_W'(span(REP_DLY_CYC));
                          end
            S_SEEK:       if (w_expire) begin
                              state_d = S_REP;        w_load = 1'b1;
                              w_load_val = CNT_W'(span(REP_W_CYC));
                          end
            S_REP:        if (w_expire) begin
                              state_d = S_HOLD;       w_load = 1'b1;
                              w_load_val = CNT_W'(span(HOLD_CYC));
                          end
            S_HOLD:       if (w_expire) begin
                              if (pages_q > c_cmd_cnt_w'(1)) begin
                                  state_d = S_LEAD;   w_load = 1'b1;
                                  w_load_val = CNT_W'(span(LEAD_CYC));
                              end else begin
                                  state_d = S_READY;
                              end
                          end
            default:      state_d = S_PWR;
        endcase
    end

    always_ff @(posedge master_clock_i) begin
        if (reset_i) begin
            state_q     <= S_PWR;
            pg_q        <= 1'b1;
            shift_q     <= 1'b1;
            rep_q       <= 1'b1;
            boot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            temp_q      <= 1'b0;
            temp_prev_q <= 1'b0;
            first_q     <= 1'b0;
            pages_q     <= '0;
            seek_q      <= '0;
        end else begin
            state_q     <= state_d;
            temp_q      <= temperature_low_i;
            temp_prev_q <= temp_q;
            pg_q        <= (state_d == S_PWR);
            shift_q     <= !(state_d inside {S_BOOT_SHIFT, S_SEEK, S_REP, S_HOLD});
            rep_q       <= (state_d != S_REP);
            busy_q      <= (state_d != S_READY);
            ready_q     <= (state_d == S_READY);
            boot_q      <= boot_q | (state_q == S_BOOT_LOOP && state_d == S_READY);
            done_q      <= (state_q == S_HOLD && state_d == S_READY)
                         | (w_accept && cmd_count_i == '0);
            if (state_q == S_READY && state_d == S_LEAD) begin
                pages_q <= cmd_count_i;
                seek_q  <= cmd_seek_i;
                first_q <= 1'b1;
            end else if (state_q == S_HOLD && state_d == S_LEAD) begin
                pages_q <= pages_q - c_cmd_cnt_w'(1);
                first_q <= 1'b0;
            end else if (state_q == S_HOLD && state_d == S_READY) begin
                pages_q <= '0;
            end
        end
    end

    assign power_good_o          = pg_q;
    assign bubble_shift_enable_o = shift_q;
    assign replicator_enable_o   = rep_q;
    assign bootloop_enable_o     = boot_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign cmd_ready_o           = ready_q;

`ifdef BUBBLE_SEQ_CAPTURE_EN
    localparam int c_div_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [c_div_w-1:0] div_q;
    logic [CH-1:0]      sample_q;
    logic               sample_vld_q;

    // Samples land in the first HOLD cycle and then every SAMPLE_DIV cycles.
    always_ff @(posedge master_clock_i) begin
        if (reset_i) begin
            div_q        <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            sample_vld_q <= 1'b0;
            if (state_d == S_HOLD) begin
                if (state_q != S_HOLD || div_q == c_div_w'(SAMPLE_DIV - 1)) begin
                    div_q        <= '0;
                    sample_q     <= bubble_out_i;
                    sample_vld_q <= 1'b1;
                end else begin
                    div_q <= div_q + c_div_w'(1);
                end
            end
        end
    end

    assign data_out_o   = sample_q;
    assign data_valid_o = sample_vld_q;
`else
    localparam int unsigned c_unused_div = SAMPLE_DIV;
    logic w_unused_bubble;

    assign w_unused_bubble = ^bubble_out_i;
    assign data_out_o      = '0;
    assign data_valid_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bubble_host_sequencer.sv
// ============================================================================
// Module   : tb_bubble_host_sequencer
// Brief    : Scoreboarded bench for bubble_host_sequencer (strobe edges, done
//            and capture samples matched by cycle against expected events).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bubble_host_sequencer;

    localparam int CH         = 4;
    localparam int CNT_W      = 22;
    localparam int PWR        = 5;
    localparam int BL         = 3;
    localparam int BS         = 8;
    localparam int BLOOP      = 2;
    localparam int LEAD       = 4;
    localparam int REP_DLY    = 3;
    localparam int REP_W      = 2;
    localparam int HOLD       = 10;
    localparam int DIV        = 4;

    logic             clk = 1'b0;
    logic             reset_i, temperature_low_i, cmd_valid_i;
    logic [CH-1:0]    bubble_out_i;
    logic [CNT_W-1:0] cmd_seek_i;
    logic [7:0]       cmd_count_i;
    logic             cmd_ready_o, power_good_o, bubble_shift_enable_o, replicator_enable_o;
    logic             bootloop_enable_o, busy_o, done_o, data_valid_o;
    logic [CH-1:0]    data_out_o;

    always #5 clk = ~clk;

    bubble_host_sequencer #(
        .CH(CH), .CNT_W(CNT_W), .PWR_DLY_CYC(PWR), .BOOT_LEAD_CYC(BL),
        .BOOT_SHIFT_CYC(BS), .BOOT_LOOP_DLY(BLOOP), .LEAD_CYC(LEAD),
        .REP_DLY_CYC(REP_DLY), .REP_W_CYC(REP_W), .HOLD_CYC(HOLD), .SAMPLE_DIV(DIV)
    ) dut (
        .master_clock_i        (clk),
        .reset_i               (reset_i),
        .temperature_low_i     (temperature_low_i),
        .bubble_out_i          (bubble_out_i),
        .cmd_valid_i           (cmd_valid_i),
        .cmd_ready_o           (cmd_ready_o),
        .cmd_seek_i            (cmd_seek_i),
        .cmd_count_i           (cmd_count_i),
        .power_good_o          (power_good_o),
        .bubble_shift_enable_o (bubble_shift_enable_o),
        .replicator_enable_o   (replicator_enable_o),
        .bootloop_enable_o     (bootloop_enable_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .data_out_o            (data_out_o),
        .data_valid_o          (data_valid_o)
    );

    // Event ids: 0 power_good, 1 shift, 2 replicator, 3 bootloop (edges);
    // 4 done, 5 data_valid (every high cycle).
    typedef struct {
        int         sig;
        int         val;
        int         cyc;
        logic [3:0] data;
    } ev_t;

    ev_t   exp_q[$];
    ev_t   e_m;
    int    cyc   = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    logic  [5:0] cur, prv;
    logic  hit;
    string nm[6] = '{"power_good", "shift_en", "rep_en", "bootloop", "done", "data_valid"};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cur = {data_valid_o, done_o, bootloop_enable_o, replicator_enable_o,
               bubble_shift_enable_o, power_good_o};
        for (int i = 0; i < 6; i++) begin
            hit = (i < 4) ? (cur[i] !== prv[i]) : (cur[i] === 1'b1);
            if (mon_en && hit) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL event: got %s=%b at cycle %0d, required no event", nm[i], cur[i], cyc);
                end else begin
                    e_m = exp_q.pop_front();
                    if (e_m.sig != i || cur[i] !== e_m.val[0] || e_m.cyc != cyc ||
                        (i == 5 && data_out_o !== e_m.data)) begin
                        n_bad++;
                        $display("FAIL event: got %s=%b at cycle %0d data %h, required %s=%0d at cycle %0d data %h",
                                 nm[i], cur[i], cyc, data_out_o, nm[e_m.sig], e_m.val, e_m.cyc, e_m.data);
                    end
                end
            end
        end
        prv = cur;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int v, input int c, input logic [3:0] d);
        exp_q.push_back(ev_t'{s, v, c, d});
    endtask

    // Expected strobe timeline of a burst whose first LEAD cycle is t0.
    task automatic expect_burst(input int t0, input int seek, input int count, output int end_cyc);
        int t, fall, repf, repr, rise, s;
        t = t0;
        for (int p = 0; p < count; p++) begin
            s    = (p == 0) ? ((seek == 0) ? 1 : seek) : REP_DLY;
            fall = t + LEAD;
            repf = fall + s;
            repr = repf + REP_W;
            rise = repr + HOLD;
            push(1, 0, fall, 4'h0);
            push(2, 0, repf, 4'h0);
            push(2, 1, repr, 4'h0);
`ifdef BUBBLE_SEQ_CAPTURE_EN
            for (int k = 0; k < HOLD; k += DIV) push(5, 1, repr + k, 4'hA);
`endif
            push(1, 1, rise, 4'h0);
            if (p == count - 1) push(4, 1, rise, 4'h0);
            t = rise;
        end
        end_cyc = t;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        step(3);
        n_cmp++;
        if ({power_good_o, bubble_shift_enable_o, replicator_enable_o, bootloop_enable_o,
             busy_o, done_o, cmd_ready_o, data_valid_o} !== 8'b1110_0000) begin
            n_bad++;
            $display("FAIL reset outputs: got %b required 11100000",
                     {power_good_o, bubble_shift_enable_o, replicator_enable_o, bootloop_enable_o,
                      busy_o, done_o, cmd_ready_o, data_valid_o});
        end
        n_cmp++;
        if (data_out_o !== 4'h0) begin
            n_bad++;
            $display("FAIL reset data_out: got %h required 0", data_out_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_boot;
        int  r, t, exp_ready;
        bit  got;
        r = cyc;
        reset_i = 1'b0;
        push(0, 0, r + PWR, 4'h0);
        step(20);
        t = cyc;
        temperature_low_i = 1'b1;
        // Two sampling registers plus the WAIT_TEMP hop precede BOOT_LEAD.
        exp_ready = t + 2 + BL + BS + BLOOP;
        push(1, 0, t + 2 + BL, 4'h0);
        push(1, 1, t + 2 + BL + BS, 4'h0);
        push(3, 1, exp_ready, 4'h0);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step(1);
            if (cmd_ready_o === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got || cyc != exp_ready) begin
            n_bad++;
            $display("FAIL boot ready: got cycle %0d (seen %0d) required cycle %0d", cyc, got, exp_ready);
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL boot busy: got %b required 0", busy_o);
        end
        step(1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL boot events: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_burst(input int seek, input int count, input int hold_cyc);
        int a, e_end;
        a = cyc;
        cmd_seek_i  = CNT_W'(seek);
        cmd_count_i = 8'(count);
        cmd_valid_i = 1'b1;
        expect_burst(a + 1, seek, count, e_end);
        step(1);
        n_cmp++;
        if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL burst start: got ready=%b busy=%b required ready=0 busy=1", cmd_ready_o, busy_o);
        end
        step(hold_cyc - 1);
        cmd_valid_i       = 1'b0;
        temperature_low_i = 1'b0;
        step(e_end - cyc);
        n_cmp++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL burst end: got ready=%b busy=%b done=%b required 1 0 1",
                     cmd_ready_o, busy_o, done_o);
        end
        step(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL burst events: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_zero_count;
        int z;
        z = cyc;
        cmd_count_i = 8'd0;
        cmd_valid_i = 1'b1;
        push(4, 1, z + 1, 4'h0);
        step(1);
        cmd_valid_i = 1'b0;
        n_cmp++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL zero count: got ready=%b busy=%b done=%b required 1 0 1",
                     cmd_ready_o, busy_o, done_o);
        end
        step(3);
        n_cmp++;
        if (exp_q.size() != 0 || bubble_shift_enable_o !== 1'b1) begin
            n_bad++;
            $display("FAIL zero count idle: got pending=%0d shift=%b required 0 and 1",
                     exp_q.size(), bubble_shift_enable_o);
        end
    endtask

    task automatic test_reset_mid_burst;
        int b, k;
        b = cyc;
        cmd_seek_i  = CNT_W'(7);
        cmd_count_i = 8'd2;
        cmd_valid_i = 1'b1;
        push(1, 0, b + 1 + LEAD, 4'h0);
        push(2, 0, b + 1 + LEAD + 7, 4'h0);
        step(1);
        cmd_valid_i = 1'b0;
        step(LEAD + 7);
        reset_i = 1'b1;
        k = cyc + 1;
        push(0, 1, k, 4'h0);
        push(1, 1, k, 4'h0);
        push(2, 1, k, 4'h0);
        push(3, 0, k, 4'h0);
        step(1);
        n_cmp++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b0 || done_o !== 1'b0 || data_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid reset: got busy=%b ready=%b done=%b valid=%b required all 0",
                     busy_o, cmd_ready_o, done_o, data_valid_o);
        end
    endtask

    initial begin
        reset_i           = 1'b1;
        temperature_low_i = 1'b0;
        cmd_valid_i       = 1'b0;
        cmd_seek_i        = '0;
        cmd_count_i       = '0;
        bubble_out_i      = 4'hA;
        test_reset;
        test_boot;
        test_burst(7, 3, 30);
        test_zero_count;
        test_reset_mid_burst;
        test_boot;
        test_burst(0, 1, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
